// File: rtl/fan_pkg.sv
// Shared definitions for the fan tachometer / fan control path.
package fan_pkg;

  localparam int unsigned US_PER_MIN = 60_000_000;
  localparam logic [15:0] RPM_SAT    = 16'hFFFF;

  typedef enum logic [1:0] {
    IDLE,
    ARM,
    MEASURE,
    DIVIDE
  } tach_state_t;

endpackage

// File: rtl/seq_divider.sv
// 32-bit unsigned restoring divider: load on start, one quotient bit per cycle,
// done pulses with the quotient 32 cycles after start. A new start restarts it.
module seq_divider (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient
);

  logic [31:0] rem_q;
  logic [31:0] quo_q;
  logic [31:0] dvs_q;
  logic [4:0]  step_q;
  logic [32:0] shifted;
  logic [32:0] diff;

  always_comb begin
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
      step_q <= '0;
      busy   <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        rem_q  <= '0;
        quo_q  <= dividend;
        dvs_q  <= divisor;
        step_q <= '0;
        busy   <= 1'b1;
      end else if (busy) begin
        // Partial remainder always stays below the divisor, so 32 bits hold it.
        if (!diff[32]) begin
          rem_q <= diff[31:0];
          quo_q <= {quo_q[30:0], 1'b1};
        end else begin
          rem_q <= shifted[31:0];
          quo_q <= {quo_q[30:0], 1'b0};
        end
        step_q <= step_q + 5'd1;
        if (step_q == 5'd31) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign quotient = quo_q;

endmodule

// File: rtl/fan_tach_meter.sv
// Measures tach period in microseconds between qualified rising edges and converts
// it to RPM; flags a stalled fan when no qualified edge arrives within the timeout.
module fan_tach_meter
  import fan_pkg::*;
#(
  parameter int PRESCALE       = 100,
  parameter int CNT_W          = 20,
  parameter int TIMEOUT_US     = 1_000_000,
  parameter int MIN_PERIOD_US  = 100,
  parameter int PULSES_PER_REV = 2
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_tach,
  input  logic             i_enable,
  output logic [CNT_W-1:0] o_period_us,
  output logic [15:0]      o_rpm,
  output logic             o_valid,
  output logic             o_stall
);

  localparam int          PS_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [31:0] NUMER   = 32'(US_PER_MIN / PULSES_PER_REV);
  localparam logic [CNT_W-1:0] TIMEOUT = CNT_W'(TIMEOUT_US);
  localparam logic [CNT_W-1:0] MIN_P   = CNT_W'(MIN_PERIOD_US);

  logic             sync1, sync2, sync2_d;
  logic             rise;
  logic [PS_W-1:0]  presc;
  logic             tick;
  logic [CNT_W-1:0] cnt, cnt_inc, period_lat;
  logic             qual, timeout_hit;
  tach_state_t      state, next_state;
  logic             cnt_clr, div_start, stall_evt, meas_evt;
  logic             div_busy, div_done;
  logic [31:0]      quotient;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      sync2_d <= 1'b0;
    end else begin
      sync1   <= i_tach;
      sync2   <= sync1;
      sync2_d <= sync2;
    end
  end

  assign rise = sync2 & ~sync2_d;
  assign tick = i_enable && (presc == PS_W'(PRESCALE - 1));

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)       presc <= '0;
    else if (!i_enable || tick) presc <= '0;
    else               presc <= presc + PS_W'(1);
  end

  // The tick landing on the edge cycle belongs to the period that edge closes.
  assign cnt_inc     = (tick && cnt != TIMEOUT) ? cnt + CNT_W'(1) : cnt;
  assign qual        = rise && (cnt_inc >= MIN_P);
  assign timeout_hit = (cnt_inc == TIMEOUT);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)      cnt <= '0;
    else if (cnt_clr) cnt <= '0;
    else              cnt <= cnt_inc;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) state <= IDLE;
    else         state <= next_state;
  end

  always_comb begin
    next_state = state;
    cnt_clr    = 1'b0;
    div_start  = 1'b0;
    stall_evt  = 1'b0;
    meas_evt   = 1'b0;
    if (!i_enable) begin
      next_state = IDLE;
      cnt_clr    = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          cnt_clr    = 1'b1;
          next_state = ARM;
        end
        ARM: begin
          cnt_clr = 1'b1;
          if (rise) next_state = MEASURE;
        end
        MEASURE: begin
          if (qual) begin
            cnt_clr    = 1'b1;
            div_start  = 1'b1;
            next_state = DIVIDE;
          end else if (timeout_hit) begin
            stall_evt  = 1'b1;
            next_state = ARM;
          end
        end
        DIVIDE: begin
          if (div_done) begin
            meas_evt   = 1'b1;
            next_state = MEASURE;
          end else if (!div_busy) begin
            next_state = MEASURE;
          end
        end
        default: next_state = IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)        period_lat <= '0;
    else if (div_start) period_lat <= cnt_inc;
  end

  seq_divider u_div (
    .clk      (i_clk),
    .reset    (i_reset),
    .start    (div_start),
    .dividend (NUMER),
    .divisor  (32'(cnt_inc)),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_period_us <= '0;
      o_rpm       <= '0;
      o_valid     <= 1'b0;
      o_stall     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (stall_evt) begin
        o_period_us <= TIMEOUT;
        o_rpm       <= '0;
        o_stall     <= 1'b1;
        o_valid     <= 1'b1;
      end else if (meas_evt) begin
        o_period_us <= period_lat;
        o_rpm       <= (quotient[31:16] != '0) ? RPM_SAT : quotient[15:0];
        o_stall     <= 1'b0;
        o_valid     <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_fan_tach_meter.sv
// Directed bench for fan_tach_meter with a scaled timebase (4 clocks per us,
// 1500 us timeout, 20 us glitch filter); expected RPM = 30_000_000 / period_us.
module tb_fan_tach_meter;

  localparam int PRESCALE      = 4;
  localparam int CNT_W         = 11;
  localparam int TIMEOUT_US    = 1500;
  localparam int MIN_PERIOD_US = 20;
  localparam int PPR           = 2;

  logic             i_clk = 1'b0;
  logic             i_reset;
  logic             i_tach;
  logic             i_enable;
  logic [CNT_W-1:0] o_period_us;
  logic [15:0]      o_rpm;
  logic             o_valid;
  logic             o_stall;

  fan_tach_meter #(
    .PRESCALE       (PRESCALE),
    .CNT_W          (CNT_W),
    .TIMEOUT_US     (TIMEOUT_US),
    .MIN_PERIOD_US  (MIN_PERIOD_US),
    .PULSES_PER_REV (PPR)
  ) dut (
    .i_clk       (i_clk),
    .i_reset     (i_reset),
    .i_tach      (i_tach),
    .i_enable    (i_enable),
    .o_period_us (o_period_us),
    .o_rpm       (o_rpm),
    .o_valid     (o_valid),
    .o_stall     (o_stall)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int gap_us;
    int exp_valid;
    int exp_period;
    int exp_rpm;
  } vec_t;

  vec_t vecs[9];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   nv, k1, k2;
  int   per_s[2];
  int   rpm_s[2];
  int   stall_s[2];

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Raise i_tach now (sampled at the next posedge, k=0), run 'cycles' clocks and
  // record every o_valid strobe seen. Optional 4-cycle glitch starting at glitch_at.
  task automatic run_edge(input int cycles, input int high, input int glitch_at);
    nv = 0; k1 = -1; k2 = -1;
    i_tach = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (o_valid) begin
        if (nv < 2) begin
          per_s[nv]   = int'(o_period_us);
          rpm_s[nv]   = int'(o_rpm);
          stall_s[nv] = int'(o_stall);
          if (nv == 0) k1 = k; else k2 = k;
        end
        nv++;
      end
      if (k + 1 == high) i_tach = 1'b0;
      if (glitch_at > 0 && k + 1 == glitch_at) i_tach = 1'b1;
      if (glitch_at > 0 && k + 1 == glitch_at + 4) i_tach = 1'b0;
    end
  endtask

  task automatic check_meas(input string name, input int period, input int rpm);
    check({name, "_nvalid"}, nv, 1);
    check({name, "_latency"}, k1, 35);
    check({name, "_period"}, per_s[0], period);
    check({name, "_rpm"}, rpm_s[0], rpm);
    check({name, "_stall"}, stall_s[0], 0);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1000, 0, 0, 0};
    vecs[1] = '{500, 1, 1000, 30000};
    vecs[2] = '{400, 1, 500, 60000};
    vecs[3] = '{458, 1, 400, 65535};
    vecs[4] = '{457, 1, 458, 65502};
    vecs[5] = '{1200, 1, 457, 65535};
    vecs[6] = '{1499, 1, 1200, 25000};
    vecs[7] = '{20, 1, 1499, 20013};
    vecs[8] = '{50, 1, 20, 65535};

    i_reset = 1'b1; i_tach = 1'b0; i_enable = 1'b0;
    repeat (4) @(negedge i_clk);
    i_reset = 1'b0;
    repeat (2) @(negedge i_clk);
    check("reset_period", int'(o_period_us), 0);
    check("reset_rpm", int'(o_rpm), 0);
    check("reset_valid", int'(o_valid), 0);
    check("reset_stall", int'(o_stall), 0);

    // Periodic measurements; the strobe in row i reports the gap of row i-1.
    i_enable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      run_edge(vecs[i].gap_us * PRESCALE, vecs[i].gap_us * PRESCALE / 2, 0);
      if (vecs[i].exp_valid == 0) check($sformatf("row%0d_nvalid", i), nv, 0);
      else check_meas($sformatf("row%0d", i), vecs[i].exp_period, vecs[i].exp_rpm);
    end

    // Enable dropped mid-MEASURE: outputs hold, no strobe.
    i_enable = 1'b0;
    nv = 0;
    for (int k = 0; k < 10 * PRESCALE; k++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (o_valid) nv++;
    end
    check("dis_nvalid", nv, 0);
    check("dis_period", int'(o_period_us), 20);
    check("dis_rpm", int'(o_rpm), 65535);
    check("dis_stall", int'(o_stall), 0);

    // Re-enable aligned with the arm edge so the timeout strobe lands at a fixed cycle.
    i_enable = 1'b1;
    run_edge(1000 * PRESCALE, 2000, 0);
    check("rearm_nvalid", nv, 0);
    run_edge(6104, 2000, 0);
    check("stall_nvalid", nv, 2);
    check("stall_meas_latency", k1, 35);
    check("stall_meas_period", per_s[0], 1000);
    check("stall_meas_rpm", rpm_s[0], 30000);
    check("stall_latency", k2, 3 + (TIMEOUT_US - 1) * PRESCALE);
    check("stall_period", per_s[1], TIMEOUT_US);
    check("stall_rpm", rpm_s[1], 0);
    check("stall_flag", stall_s[1], 1);
    check("stall_hold", int'(o_stall), 1);

    run_edge(1000 * PRESCALE, 2000, 0);
    check("stall_arm_nvalid", nv, 0);
    check("stall_arm_hold", int'(o_stall), 1);
    // Next edge arrives on the very tick that reaches the timeout.
    run_edge(3 + (TIMEOUT_US - 1) * PRESCALE - 2, 2000, 0);
    check_meas("recover", 1000, 30000);
    run_edge(1250 * PRESCALE, 4, 40);
    check_meas("edge_wins", TIMEOUT_US, 20000);
    run_edge(400 * PRESCALE, 800, 0);
    check_meas("glitch", 1250, 24000);

    // Reset while the 400 us period is being divided.
    nv = 0;
    i_tach = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (o_valid) nv++;
      if (k == 10) i_tach = 1'b0;
    end
    i_reset = 1'b1;
    @(posedge i_clk);
    @(negedge i_clk);
    check("rst_div_period", int'(o_period_us), 0);
    check("rst_div_rpm", int'(o_rpm), 0);
    check("rst_div_valid", int'(o_valid), 0);
    check("rst_div_stall", int'(o_stall), 0);
    repeat (3) @(negedge i_clk);
    i_reset = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(posedge i_clk);
      @(negedge i_clk);
      if (o_valid) nv++;
    end
    check("rst_div_nvalid", nv, 0);
    run_edge(500 * PRESCALE, 1000, 0);
    check("rst_arm_nvalid", nv, 0);
    run_edge(50 * PRESCALE, 100, 0);
    check_meas("rst_after", 500, 60000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fan_tach_meter.md
# fan_tach_meter

Measures the period of the fan's open-drain tachometer output and converts it to RPM for the fan-control FSM. It sits on the input side of the fan path, opposite the PWM/clock-divider chain that drives the fan. Internally it derives a 1 µs timebase from i_clk, counts microseconds between qualified rising tach edges, and runs a sequential divide to produce RPM. It also flags a stalled fan by timeout.

## Interface
- PRESCALE, 100: i_clk cycles per 1 µs tick (100 MHz system clock).
- CNT_W, 20: period counter width; must hold TIMEOUT_US.
- TIMEOUT_US, 1_000_000: µs without a qualified edge before stall is declared.
- MIN_PERIOD_US, 100: edges closer than this to the previous qualified edge are rejected as glitches. MIN_PERIOD_US*PRESCALE must exceed 40.
- PULSES_PER_REV, 2: tach pulses per revolution.
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-high reset.
- i_tach  in  1  raw tach input, asynchronous to i_clk.
- i_enable  in  1  measurement enable, level.
- o_period_us  out  CNT_W  last measured period in µs; TIMEOUT_US on stall.
- o_rpm  out  16  last RPM, saturated at 65535; 0 on stall.
- o_valid  out  1  one-cycle strobe; o_period_us, o_rpm and o_stall are updated in the same cycle.
- o_stall  out  1  high from timeout until the next valid measurement.

## Operation
- i_tach passes through a 2-FF synchronizer. A rising edge is sync2 & ~sync2_d.
- The tick generator counts 0..PRESCALE-1 and pulses on the terminal count. It runs only while i_enable=1 and is cleared otherwise.
- The µs counter increments on each tick and saturates at TIMEOUT_US. It clears on entry to MEASURE.
- States:
  - IDLE: i_enable=0. Counters are cleared and outputs hold their values. Go to ARM when i_enable=1.
  - ARM: waits for the first edge. On an edge, clear the counter and go to MEASURE. The first edge never produces o_valid.
  - MEASURE:
    - Edge with count < MIN_PERIOD_US: ignored; counting continues.
    - Edge with count >= MIN_PERIOD_US: latch count as period, clear the counter, go to DIVIDE.
    - Count reaches TIMEOUT_US: set o_period_us=TIMEOUT_US, o_rpm=0, o_stall=1, pulse o_valid, go to ARM.
  - DIVIDE: 32-cycle restoring divide of US_PER_MIN/PULSES_PER_REV (30_000_000 at default) by the latched period. Edges are ignored in this state. The µs counter keeps running.
    - Quotient > 65535 gives o_rpm=65535.
    - On completion, update o_period_us and o_rpm, clear o_stall, pulse o_valid, and return to MEASURE.
- i_enable=0 in any state returns to IDLE on the next clock and abandons any divide in progress.
- Widths: 32-bit numerator, 32-bit quotient. The divisor is zero-extended from CNT_W bits. The divisor is never 0 (MIN_PERIOD_US >= 1).

## Timing
- Reset values: o_period_us=0, o_rpm=0, o_valid=0, o_stall=0. The FSM resets to IDLE.
- Latency: if i_tach is first sampled high at edge N, o_valid is high for exactly one cycle after edge N+35. This covers 2 sync stages, 1 edge/latch cycle, 32 divide cycles and 1 output register.
- Stall: o_valid and o_stall rise in the cycle after the tick that brings the count to TIMEOUT_US.
- A qualified edge in the same cycle as the count reaching TIMEOUT_US: the edge wins and is measured with period TIMEOUT_US.
- Reset mid-DIVIDE clears everything immediately. After release, the block needs a fresh ARM edge.
- o_valid spacing is at least MIN_PERIOD_US µs apart, except for the first stall after ARM.

## Structure
- Shared package fan_pkg holds:
  - US_PER_MIN = 60_000_000
  - the tach state enum (IDLE, ARM, MEASURE, DIVIDE)
  - the RPM saturation constant 16'hFFFF
- One sub-module, seq_divider: a 32-bit unsigned restoring divider with start/busy/done and a 32-cycle fixed latency. It is reusable by the PWM duty computation.
- The synchronizer, tick generator, counter and FSM stay in fan_tach_meter.

## Test plan
- 10 ms square wave on i_tach, i_enable=1 → the first edge gives no strobe. After the second edge: o_valid with o_period_us=10000, o_rpm=3000, o_stall=0, at edge N+35.
- Arm with one edge, then hold i_tach low for 1.2 s → o_valid with o_stall=1, o_period_us=1_000_000, o_rpm=0 at exactly 1_000_000 µs. Next 10 ms edge pair → o_stall=0.
- 200 ns glitch 50 µs after a qualified edge inside a 5 ms period → glitch ignored; o_period_us=5000, o_rpm=6000.
- 400 µs period → o_period_us=400, o_rpm=65535 (quotient 75000 saturated).
- Assert i_reset during DIVIDE → all outputs 0 next cycle, no o_valid. After release, the first edge produces no strobe.
- Drop i_enable mid-MEASURE for 10 µs, then re-raise → outputs hold their values, no o_valid. Measurement restarts from ARM.
